// File: rtl/fir_pkg.sv
// fir_pkg: shared types and address map for the FIR loader and filter pair
package fir_pkg;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_DATA_W   = 8;
  localparam int FIR_IN_BASE  = 0;
  localparam int FIR_OUT_BASE = 512;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_KICK, S_RUN} state_t;
endpackage

// File: rtl/fir_watchdog.sv
// fir_watchdog: loadable up-counter with clear and enable, flags expiry of a cycle budget
module fir_watchdog #(
  parameter int LIMIT = 65535,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] count;
  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (load) count <= load_val;
    else if (en) count <= count + 1'b1;
  end
  // expiry fires in the cycle whose increment would reach LIMIT
  always_comb expired = en && (count >= W'(LIMIT - 1));
endmodule

// File: rtl/fir_sample_loader.sv
// fir_sample_loader: streams samples into the FIR input BRAM region, kicks the filter and waits for done
module fir_sample_loader
  import fir_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int BASE_ADDR      = FIR_IN_BASE,
  parameter int SAMPLE_COUNT   = 100,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              fir_start,
  input  logic              fir_done,
  output logic              busy,
  output logic              batch_done,
  output logic              err_timeout,
  output logic [ADDR_W:0]   loaded_count
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_nx;
  logic xfer, accept, last, wd_expired;
  logic [ADDR_W:0] cnt_inc;
  always_comb begin
    s_ready   = state == S_LOAD;
    fir_start = state == S_KICK;
    busy      = state != S_IDLE;
    xfer      = s_ready && s_valid;
    accept    = state == S_IDLE && load_req && !batch_done;
    cnt_inc   = loaded_count + 1'b1;
    last      = xfer && cnt_inc == (ADDR_W + 1)'(SAMPLE_COUNT);
    state_nx  = state;
    case (state)
      S_IDLE:  state_nx = accept ? S_LOAD : S_IDLE;
      S_LOAD:  state_nx = last ? S_FLUSH : S_LOAD;
      S_FLUSH: state_nx = S_KICK;
      S_KICK:  state_nx = S_RUN;
      S_RUN:   state_nx = (fir_done || wd_expired) ? S_IDLE : S_RUN;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      batch_done   <= 1'b0;
      err_timeout  <= 1'b0;
      loaded_count <= '0;
    end else begin
      state        <= state_nx;
      mem_we       <= xfer;
      if (xfer) begin
        mem_addr <= ADDR_W'(BASE_ADDR) + loaded_count[ADDR_W-1:0];
        mem_data <= s_data;
      end
      loaded_count <= accept ? '0 : xfer ? cnt_inc : loaded_count;
      batch_done   <= state == S_RUN && fir_done;
      err_timeout  <= accept ? 1'b0 : (state == S_RUN && wd_expired && !fir_done) ? 1'b1 : err_timeout;
    end
  end
  // KICK counts as the first elapsed cycle of the run budget
  fir_watchdog #(.LIMIT(TIMEOUT_CYCLES), .W(WD_W)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == S_IDLE),
    .load     (state == S_KICK),
    .en       (state == S_RUN),
    .load_val (WD_W'(1)),
    .expired  (wd_expired)
  );
endmodule

// File: tb/tb_fir_sample_loader.sv
// tb_fir_sample_loader: directed vector table plus hand sequences for the sample loader
module tb_fir_sample_loader;
  logic clk = 1'b0, rst = 1'b1, load_req = 1'b0, s_valid = 1'b0, fir_done = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, mem_we, fir_start, busy, batch_done, err_timeout;
  logic [9:0] mem_addr;
  logic [7:0] mem_data;
  logic [10:0] loaded_count;
  logic s_ready2, mem_we2, fir_start2, busy2, batch_done2, err2;
  logic [3:0] mem_addr2;
  logic [7:0] mem_data2;
  logic [4:0] cnt2;
  int total = 0, bad = 0;

  fir_sample_loader #(.ADDR_W(10), .DATA_W(8), .BASE_ADDR(0), .SAMPLE_COUNT(4), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .fir_start(fir_start), .fir_done(fir_done),
    .busy(busy), .batch_done(batch_done), .err_timeout(err_timeout), .loaded_count(loaded_count));

  fir_sample_loader #(.ADDR_W(4), .DATA_W(8), .BASE_ADDR(14), .SAMPLE_COUNT(4), .TIMEOUT_CYCLES(20)) dut_wrap (
    .clk(clk), .rst(rst), .load_req(load_req), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2),
    .mem_addr(mem_addr2), .mem_data(mem_data2), .mem_we(mem_we2), .fir_start(fir_start2), .fir_done(fir_done),
    .busy(busy2), .batch_done(batch_done2), .err_timeout(err2), .loaded_count(cnt2));

  always #5 clk = ~clk;

  typedef struct {
    logic lr, v; logic [7:0] d; logic fd; int n;
    logic rdy, we; logic [9:0] a; logic [3:0] a2; logic [7:0] md;
    logic st, bz, bd, er; logic [10:0] cnt;
  } vec_t;
  vec_t tbl [9];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [57:0] snap();
    return {s_ready, mem_we, mem_addr, mem_addr2, mem_data, fir_start, busy, batch_done, err_timeout, loaded_count,
            s_ready2, mem_we2, mem_data2, fir_start2, busy2, batch_done2, err2, cnt2};
  endfunction

  function automatic logic [57:0] expv(input vec_t v);
    return {v.rdy, v.we, v.a, v.a2, v.md, v.st, v.bz, v.bd, v.er, v.cnt,
            v.rdy, v.we, v.md, v.st, v.bz, v.bd, v.er, v.cnt[4:0]};
  endfunction

  task automatic run_load(input logic [7:0] d0);
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data = d0 + 8'(i);
      tick;
      if (i == 0) chk("first_wr", 64'({mem_we, mem_addr, mem_addr2, mem_data}), 64'({1'b1, 10'd0, 4'd14, d0}));
    end
    s_valid = 1'b0;
    tick;
    chk("kick", 64'({fir_start, fir_start2}), 64'(2'b11));
  endtask

  initial begin
    logic [0:6] pat;
    int nw;
    logic early;
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1,  1'b1, 1'b0, 10'd0, 4'd0,  8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0};
    tbl[1] = '{1'b0, 1'b1, 8'h11, 1'b0, 1,  1'b1, 1'b1, 10'd0, 4'd14, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 11'd1};
    tbl[2] = '{1'b0, 1'b1, 8'h22, 1'b0, 1,  1'b1, 1'b1, 10'd1, 4'd15, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 11'd2};
    tbl[3] = '{1'b0, 1'b1, 8'h33, 1'b0, 1,  1'b1, 1'b1, 10'd2, 4'd0,  8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 11'd3};
    tbl[4] = '{1'b0, 1'b1, 8'h44, 1'b0, 1,  1'b0, 1'b1, 10'd3, 4'd1,  8'h44, 1'b0, 1'b1, 1'b0, 1'b0, 11'd4};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1,  1'b0, 1'b0, 10'd3, 4'd1,  8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 11'd4};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 10, 1'b0, 1'b0, 10'd3, 4'd1,  8'h44, 1'b0, 1'b1, 1'b0, 1'b0, 11'd4};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1,  1'b0, 1'b0, 10'd3, 4'd1,  8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 11'd4};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1,  1'b0, 1'b0, 10'd3, 4'd1,  8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 11'd4};

    repeat (2) tick;
    chk("reset", 64'(snap()), 64'(0));
    rst = 1'b0;

    // normal batch and address wrap on the narrow instance
    for (int i = 0; i < 9; i++)
      for (int k = 0; k < tbl[i].n; k++) begin
        load_req = tbl[i].lr;
        s_valid = tbl[i].v;
        s_data = tbl[i].d;
        fir_done = tbl[i].fd;
        tick;
        chk($sformatf("vec%0d.%0d", i, k), 64'(snap()), 64'(expv(tbl[i])));
      end
    load_req = 1'b0; s_valid = 1'b0; fir_done = 1'b0;

    // gaps in s_valid, then a surplus sample
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    chk("t2_start", 64'({s_ready, loaded_count}), 64'({1'b1, 11'd0}));
    pat = 7'b1001101;
    nw = 0;
    for (int i = 0; i < 7; i++) begin
      s_valid = pat[i];
      s_data = 8'hA0 + 8'(i);
      tick;
      if (pat[i]) begin
        chk("t2_wr", 64'({mem_we, mem_addr, mem_data}), 64'({1'b1, 10'(nw), 8'hA0 + 8'(i)}));
        nw++;
      end else chk("t2_gap", 64'(mem_we), 64'(0));
    end
    chk("t2_ready_drop", 64'(s_ready), 64'(0));
    s_valid = 1'b1;
    s_data = 8'h99;
    tick;
    s_valid = 1'b0;
    chk("t2_no5th", 64'({mem_we, s_ready, fir_start, loaded_count}), 64'({1'b0, 1'b0, 1'b1, 11'd4}));

    // load_req during RUN and in the batch_done cycle is ignored
    load_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t5_run_lr", 64'({busy, fir_start, s_ready, loaded_count}), 64'({1'b1, 1'b0, 1'b0, 11'd4}));
    end
    fir_done = 1'b1;
    tick;
    fir_done = 1'b0;
    chk("t2_done", 64'({batch_done, busy}), 64'(2'b10));
    tick;
    load_req = 1'b0;
    chk("t5_done_lr", 64'({busy, batch_done, loaded_count}), 64'({1'b0, 1'b0, 11'd4}));

    // watchdog expiry
    run_load(8'h51);
    early = 1'b0;
    for (int j = 1; j < 20; j++) begin
      tick;
      if (err_timeout || err2 || !busy || batch_done) early = 1'b1;
    end
    chk("t3_early", 64'(early), 64'(0));
    tick;
    chk("t3_err", 64'({err_timeout, err2, busy, batch_done}), 64'(4'b1100));
    repeat (3) tick;
    chk("t3_sticky", 64'({err_timeout, busy, batch_done}), 64'(3'b100));
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    chk("t3_clear", 64'({err_timeout, err2, busy}), 64'(3'b001));

    // reset after two samples
    s_valid = 1'b1;
    s_data = 8'h61;
    tick;
    s_data = 8'h62;
    tick;
    chk("t4_pre", 64'({mem_addr, loaded_count}), 64'({10'd1, 11'd2}));
    rst = 1'b1;
    s_data = 8'h63;
    tick;
    chk("t4_rst", 64'(snap()), 64'(0));
    rst = 1'b0;
    s_valid = 1'b0;

    // fir_done while idle is ignored
    fir_done = 1'b1;
    repeat (2) tick;
    fir_done = 1'b0;
    chk("t5_idle_done", 64'({busy, batch_done, s_ready}), 64'(0));

    // full batch restarts at base, then fir_done coincides with expiry
    run_load(8'h71);
    for (int j = 1; j < 20; j++) tick;
    fir_done = 1'b1;
    tick;
    fir_done = 1'b0;
    chk("t5_coinc", 64'({batch_done, err_timeout, busy, batch_done2, err2}), 64'(5'b10010));
    tick;
    chk("t5_after", 64'({batch_done, err_timeout, busy}), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
